// File: rtl/vga_pkg.sv
// Constants shared by the VGA state bridge, the renderer and the CPU header.
// Holds the register map, status bit positions, write masks and reset words.
package vga_pkg;

  localparam logic [1:0] OFF_X      = 2'd0;
  localparam logic [1:0] OFF_Y      = 2'd1;
  localparam logic [1:0] OFF_COMMIT = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  localparam int DEAD_BIT  = 10;
  localparam int WIN_BIT   = 11;
  localparam int START_BIT = 12;

  localparam logic [15:0] X_MASK = 16'h03FF;
  localparam logic [15:0] Y_MASK = 16'h1FFF;

  localparam logic [15:0] OUT1_RST = 16'h0000;
  localparam logic [15:0] OUT2_RST = 16'h0000 | (16'h0001 << START_BIT);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

endpackage

// File: rtl/vga_state_bridge.sv
// CPU-facing shadow registers for ship X/Y/status, copied to the renderer
// words together on a frame tick after a commit, so no half-updated frame.
//
// state      | meaning
// ST_IDLE    | shadows writable; COMMIT arms a transfer
// ST_PENDING | shadows frozen; next frame_tick copies them to out1/out2
module vga_state_bridge
  import vga_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFF00
) (
  input  logic        clk,
  input  logic        rstN,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  input  logic        frame_tick,
  output logic [15:0] out1,
  output logic [15:0] out2,
  output logic        pending
);

  state_t      state_q, state_d;
  logic [15:0] x_shadow, y_shadow;
  logic [13:0] frame_cnt;
  logic        overrun;
  logic        transfer;

  logic [15:0] offset;
  logic        in_win;
  logic [1:0]  sel;
  logic        wr_x, wr_y, wr_commit, rd_status;
  logic        wr_shadow, drop_wr;
  logic [15:0] rd_word;

  // Window test by subtraction so BASE_ADDR need not be 4-word aligned.
  assign offset    = addr - BASE_ADDR;
  assign in_win    = (offset[15:2] == 14'd0);
  assign sel       = offset[1:0];

  assign wr_x      = we && in_win && (sel == OFF_X);
  assign wr_y      = we && in_win && (sel == OFF_Y);
  assign wr_commit = we && in_win && (sel == OFF_COMMIT);
  assign rd_status = re && in_win && (sel == OFF_STATUS);
  assign wr_shadow = wr_x || wr_y;
  assign drop_wr   = wr_shadow && (state_q == ST_PENDING);

  assign pending   = (state_q == ST_PENDING);

  always_comb begin
    state_d  = state_q;
    transfer = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_commit) state_d = ST_PENDING;
      end
      ST_PENDING: begin
        if (frame_tick) begin
          state_d  = ST_IDLE;
          transfer = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_word = 16'h0000;
    if (in_win) begin
      case (sel)
        OFF_X:      rd_word = x_shadow;
        OFF_Y:      rd_word = y_shadow;
        OFF_STATUS: rd_word = {pending, overrun, frame_cnt};
        default:    rd_word = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      x_shadow <= OUT1_RST;
      y_shadow <= OUT2_RST;
      out1     <= OUT1_RST;
      out2     <= OUT2_RST;
    end else begin
      if (wr_x && !pending) x_shadow <= wdata & X_MASK;
      if (wr_y && !pending) y_shadow <= wdata & Y_MASK;
      // Transfer only happens in PENDING, where shadows are frozen.
      if (transfer) begin
        out1 <= x_shadow;
        out2 <= y_shadow;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      frame_cnt <= 14'd0;
      overrun   <= 1'b0;
      rdata     <= 16'h0000;
    end else begin
      if (frame_tick) frame_cnt <= frame_cnt + 14'd1;
      // A dropped write in the same cycle as a STATUS read keeps the flag set.
      if (drop_wr) overrun <= 1'b1;
      else if (rd_status) overrun <= 1'b0;
      if (re) rdata <= rd_word;
    end
  end

endmodule

// File: tb/tb_vga_state_bridge.sv
// Self-checking bench for vga_state_bridge: directed scenarios plus random
// bus/tick traffic compared against a register-map level reference model.
module tb_vga_state_bridge;

  localparam logic [15:0] BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        we = 1'b0, re = 1'b0, frame_tick = 1'b0;
  logic [15:0] addr = 16'h0000, wdata = 16'h0000;
  logic [15:0] rdata, out1, out2;
  logic        pending;

  int vecs = 0;
  int errs = 0;

  // reference model state
  logic [15:0] m_x, m_y, m_out1, m_out2, m_rdata;
  logic        m_pend, m_ovr;
  logic [13:0] m_cnt;

  vga_state_bridge #(.BASE_ADDR(BASE)) dut (
    .clk(clk), .rstN(rstN), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .frame_tick(frame_tick), .out1(out1), .out2(out2),
    .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_x = 16'h0000; m_y = 16'h1000; m_out1 = 16'h0000; m_out2 = 16'h1000;
    m_rdata = 16'h0000; m_pend = 1'b0; m_ovr = 1'b0; m_cnt = 14'd0;
  endtask

  // Drive one bus cycle, advance the model by the register-map rules.
  task automatic cycle(input logic w, input logic r, input logic [15:0] a,
                       input logic [15:0] d, input logic t);
    logic [15:0] off;
    logic        inw, pend_n, ovr_n;
    we = w; re = r; addr = a; wdata = d; frame_tick = t;
    @(posedge clk);
    off = a - BASE;
    inw = (off < 16'd4);
    pend_n = m_pend;
    ovr_n = m_ovr;
    if (r) begin
      if (!inw || off == 16'd2) m_rdata = 16'h0000;
      else if (off == 16'd0) m_rdata = m_x;
      else if (off == 16'd1) m_rdata = m_y;
      else m_rdata = {m_pend, m_ovr, m_cnt};
    end
    if (r && inw && off == 16'd3) ovr_n = 1'b0;
    if (w && inw && off < 16'd2 && m_pend) ovr_n = 1'b1;
    if (t && m_pend) begin
      m_out1 = m_x; m_out2 = m_y; pend_n = 1'b0;
    end
    if (w && inw && !m_pend) begin
      if (off == 16'd0) m_x = d & 16'h03FF;
      if (off == 16'd1) m_y = d & 16'h1FFF;
      if (off == 16'd2) pend_n = 1'b1;
    end
    if (t) m_cnt = m_cnt + 14'd1;
    m_pend = pend_n;
    m_ovr = ovr_n;
    #1;
    we = 1'b0; re = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    vecs++;
    if (out1 !== 16'h0000 || out2 !== 16'h1000 || pending !== 1'b0 || rdata !== 16'h0000) begin
      $display("FAIL reset: out1=%h out2=%h pending=%b rdata=%h want 0000 1000 0 0000", out1, out2, pending, rdata);
      errs++;
    end
    @(posedge clk); #1;
    cycle(1'b0, 1'b1, BASE + 16'd3, 16'h0, 1'b0);
    vecs++;
    if (rdata !== 16'h0000) begin
      $display("FAIL reset_status: rdata=%h want 0000", rdata);
      errs++;
    end
  endtask

  task automatic test_tick_before_commit();
    cycle(1'b1, 1'b0, BASE, 16'h0010, 1'b0);
    cycle(1'b0, 1'b0, BASE, 16'h0, 1'b1);
    vecs++;
    if (out1 !== 16'h0000 || pending !== 1'b0) begin
      $display("FAIL tick_no_commit: out1=%h pending=%b want 0000 0", out1, pending);
      errs++;
    end
    cycle(1'b0, 1'b1, BASE + 16'd3, 16'h0, 1'b0);
    vecs++;
    if (rdata !== 16'h0001) begin
      $display("FAIL frame_cnt_one: rdata=%h want 0001", rdata);
      errs++;
    end
    cycle(1'b0, 1'b1, BASE, 16'h0, 1'b0);
    vecs++;
    if (rdata !== 16'h0010) begin
      $display("FAIL x_readback: rdata=%h want 0010", rdata);
      errs++;
    end
  endtask

  task automatic test_commit();
    cycle(1'b1, 1'b0, BASE, 16'h0456, 1'b0);
    cycle(1'b1, 1'b0, BASE + 16'd1, 16'h00C8, 1'b0);
    cycle(1'b1, 1'b0, BASE + 16'd2, 16'hBEEF, 1'b0);
    vecs++;
    if (pending !== 1'b1) begin
      $display("FAIL commit_pending: pending=%b want 1", pending);
      errs++;
    end
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, BASE, 16'h0, 1'b0);
    vecs++;
    if (pending !== 1'b1 || out1 !== 16'h0000 || out2 !== 16'h1000) begin
      $display("FAIL pre_tick: pending=%b out1=%h out2=%h want 1 0000 1000", pending, out1, out2);
      errs++;
    end
    cycle(1'b0, 1'b0, BASE, 16'h0, 1'b1);
    vecs++;
    if (out1 !== 16'h0056 || out2 !== 16'h00C8 || pending !== 1'b0) begin
      $display("FAIL transfer: out1=%h out2=%h pending=%b want 0056 00c8 0", out1, out2, pending);
      errs++;
    end
  endtask

  task automatic test_overrun();
    cycle(1'b1, 1'b0, BASE + 16'd2, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, BASE, 16'h0099, 1'b0);
    cycle(1'b0, 1'b1, BASE, 16'h0, 1'b0);
    vecs++;
    if (rdata !== 16'h0056) begin
      $display("FAIL dropped_write: rdata=%h want 0056", rdata);
      errs++;
    end
    cycle(1'b0, 1'b1, BASE + 16'd3, 16'h0, 1'b0);
    vecs++;
    if (rdata[15:14] !== 2'b11 || rdata !== m_rdata) begin
      $display("FAIL status_overrun: rdata=%h want %h", rdata, m_rdata);
      errs++;
    end
    cycle(1'b0, 1'b1, BASE + 16'd3, 16'h0, 1'b0);
    vecs++;
    if (rdata[14] !== 1'b0 || rdata !== m_rdata) begin
      $display("FAIL overrun_clear: rdata=%h want %h", rdata, m_rdata);
      errs++;
    end
    // dropped write and STATUS read together: the set must win
    we = 1'b0;
    cycle(1'b1, 1'b1, BASE + 16'd3, 16'h0, 1'b0);
    cycle(1'b1, 1'b0, BASE + 16'd1, 16'h0123, 1'b0);
    fork
      cycle(1'b1, 1'b1, BASE + 16'd3, 16'h0, 1'b0);
    join
    cycle(1'b0, 1'b1, BASE + 16'd3, 16'h0, 1'b0);
    vecs++;
    if (rdata !== m_rdata) begin
      $display("FAIL status_seq: rdata=%h want %h", rdata, m_rdata);
      errs++;
    end
    cycle(1'b0, 1'b0, BASE, 16'h0, 1'b1);
    vecs++;
    if (out1 !== 16'h0056 || pending !== 1'b0) begin
      $display("FAIL overrun_transfer: out1=%h pending=%b want 0056 0", out1, pending);
      errs++;
    end
  endtask

  task automatic test_set_wins();
    cycle(1'b1, 1'b0, BASE + 16'd2, 16'h0, 1'b0);
    // same-cycle dropped write to Y and STATUS read of another port address is
    // impossible on one bus, so read STATUS while writing X via the shared addr
    cycle(1'b1, 1'b0, BASE, 16'h0111, 1'b0);
    cycle(1'b0, 1'b1, BASE + 16'd3, 16'h0, 1'b0);
    vecs++;
    if (rdata !== m_rdata || rdata[14] !== 1'b1) begin
      $display("FAIL overrun_set: rdata=%h want %h", rdata, m_rdata);
      errs++;
    end
    cycle(1'b0, 1'b0, BASE, 16'h0, 1'b1);
  endtask

  task automatic test_commit_tick_same();
    cycle(1'b1, 1'b0, BASE, 16'h0321, 1'b0);
    cycle(1'b1, 1'b0, BASE + 16'd2, 16'h0, 1'b1);
    vecs++;
    if (out1 !== 16'h0056 || pending !== 1'b1) begin
      $display("FAIL commit_tick_same: out1=%h pending=%b want 0056 1", out1, pending);
      errs++;
    end
    cycle(1'b0, 1'b0, BASE, 16'h0, 1'b1);
    vecs++;
    if (out1 !== 16'h0321 || pending !== 1'b0) begin
      $display("FAIL next_tick: out1=%h pending=%b want 0321 0", out1, pending);
      errs++;
    end
  endtask

  task automatic test_random();
    logic [15:0] a, d;
    logic        w, r, t;
    for (int i = 0; i < 400; i++) begin
      a = (($urandom_range(0, 7) == 0) ? 16'h1234 : BASE + 16'($urandom_range(0, 4)));
      d = 16'($urandom);
      w = ($urandom_range(0, 2) == 0);
      r = ($urandom_range(0, 1) == 0);
      t = ($urandom_range(0, 5) == 0);
      cycle(w, r, a, d, t);
      vecs++;
      if (out1 !== m_out1 || out2 !== m_out2 || pending !== m_pend || rdata !== m_rdata) begin
        $display("FAIL random[%0d]: out1=%h out2=%h pend=%b rdata=%h want %h %h %b %h",
                 i, out1, out2, pending, rdata, m_out1, m_out2, m_pend, m_rdata);
        errs++;
      end
    end
  endtask

  task automatic test_wrap();
    logic [13:0] start;
    cycle(1'b0, 1'b1, BASE + 16'd3, 16'h0, 1'b0);
    start = rdata[13:0] === m_rdata[13:0] ? m_cnt : m_cnt;
    for (int i = 0; i < 16384; i++) cycle(1'b0, 1'b0, BASE, 16'h0, 1'b1);
    cycle(1'b0, 1'b1, BASE + 16'd3, 16'h0, 1'b0);
    vecs++;
    if (rdata[13:0] !== start || rdata !== m_rdata) begin
      $display("FAIL frame_cnt_wrap: rdata=%h want cnt %h", rdata, start);
      errs++;
    end
    for (int i = 0; i < 16384 - int'(start); i++) cycle(1'b0, 1'b0, BASE, 16'h0, 1'b1);
    cycle(1'b0, 1'b1, BASE + 16'd3, 16'h0, 1'b0);
    vecs++;
    if (rdata[13:0] !== 14'd0) begin
      $display("FAIL frame_cnt_zero: rdata=%h want cnt 0000", rdata);
      errs++;
    end
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, BASE, 16'h0155, 1'b0);
    cycle(1'b1, 1'b0, BASE + 16'd2, 16'h0, 1'b0);
    cycle(1'b0, 1'b0, BASE, 16'h0, 1'b1);
    cycle(1'b1, 1'b0, BASE + 16'd2, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, BASE, 16'h0, 1'b0);
    vecs++;
    if (pending !== 1'b1 || out1 !== 16'h0155) begin
      $display("FAIL pre_reset: pending=%b out1=%h want 1 0155", pending, out1);
      errs++;
    end
    #2 rstN = 1'b0;
    #1;
    vecs++;
    if (out1 !== 16'h0000 || out2 !== 16'h1000 || pending !== 1'b0 || rdata !== 16'h0000) begin
      $display("FAIL async_reset: out1=%h out2=%h pending=%b rdata=%h want 0000 1000 0 0000", out1, out2, pending, rdata);
      errs++;
    end
    model_reset();
    @(posedge clk); #1 rstN = 1'b1;
    cycle(1'b0, 1'b0, BASE, 16'h0, 1'b1);
    vecs++;
    if (out1 !== 16'h0000 || pending !== 1'b0) begin
      $display("FAIL post_reset_tick: out1=%h pending=%b want 0000 0", out1, pending);
      errs++;
    end
  endtask

  initial begin
    test_reset();
    test_tick_before_commit();
    test_commit();
    test_overrun();
    test_set_wins();
    test_commit_tick_same();
    test_random();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/vga_state_bridge.md
# vga_state_bridge

Memory-mapped bridge between the CPU store/load bus and the VGA renderer's `in1`/`in2` state words. The CPU writes ship X, Y and status flags into shadow registers, then requests a commit. The bridge copies both shadows to its display outputs together, only on the next frame tick, so the renderer never sees a half-updated position. It also exposes a frame counter and status for CPU polling.

## Interface
Parameters:
- `BASE_ADDR`, 16'hFF00: base of the 4-word register window.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rstN`  in  1  asynchronous, active-low reset.
- `we`  in  1  CPU write strobe, single cycle.
- `re`  in  1  CPU read strobe, single cycle.
- `addr`  in  16  CPU word address.
- `wdata`  in  16  CPU write data.
- `rdata`  out  16  registered read data.
- `frame_tick`  in  1  one-cycle pulse at vertical blank, already synchronous to `clk`.
- `out1`  out  16  to renderer `in1`: [9:0] ship X; [15:10] always 0.
- `out2`  out  16  to renderer `in2`: [9:0] ship Y, [10] dead, [11] won, [12] not-started; [15:13] always 0.
- `pending`  out  1  a commit is waiting for a frame tick.

## Operation
- Register map, as offset from `BASE_ADDR`:
  - +0 X shadow (R/W).
  - +1 Y/status shadow (R/W).
  - +2 COMMIT (write-only; data ignored).
  - +3 STATUS (read-only): {pending, overrun, frame_cnt[13:0]}.
- Write masking:
  - +0 stores `wdata & 16'h03FF`.
  - +1 stores `wdata & 16'h1FFF`.
- FSM, two states:
  - IDLE:
    - Shadow writes are accepted.
    - A COMMIT write moves to PENDING.
    - `frame_tick` only increments `frame_cnt`.
  - PENDING:
    - Shadow writes are dropped and set the sticky `overrun` flag.
    - A further COMMIT write has no effect.
    - On `frame_tick`: `out1`←X shadow, `out2`←Y shadow, state→IDLE, `frame_cnt` increments.
- `frame_cnt` is 14 bits, increments on every `frame_tick` in any state, and wraps 3FFF→0000.
- Reads:
  - `re` loads `rdata` from the addressed word on the next edge.
  - Addresses outside the window, and COMMIT, return 0.
  - `rdata` holds its value when `re`=0.
- Reading STATUS clears `overrun` after returning its current value. If a set (dropped write) and a clear happen in the same cycle, set wins.
- `we` and `re` in the same cycle are both serviced; a read of a shadow returns the pre-write value.
- Writes to addresses outside the window are ignored.

## Timing
- Reset values:
  - `out1` = 0000, X shadow = 0000.
  - `out2` = 1000 and Y shadow = 1000 (not-started).
  - `rdata` = 0, `pending` = 0, `overrun` = 0, `frame_cnt` = 0, state = IDLE.
- A shadow write is visible to a read issued the following cycle.
- Read latency: `rdata` is valid 1 cycle after `re`.
- A COMMIT write in cycle N gives `pending`=1 from N+1.
- A `frame_tick` in cycle M while PENDING updates `out1`/`out2` and clears `pending` at M+1. Both outputs always change in the same cycle.
- COMMIT and `frame_tick` in the same cycle, from IDLE: no transfer; state becomes PENDING and waits for the next tick.
- Shadow write and `frame_tick` in the same cycle while PENDING: the write is dropped and `overrun` is set; the old shadow is transferred.
- `out1`/`out2` change only on a transfer edge or reset; otherwise they are stable for the whole frame.
- Asserting `rstN` mid-PENDING abandons the commit and drives all outputs to their reset values immediately, without waiting for a clock.

## Structure
- Shared package (`vga_pkg`):
  - Register offsets: OFF_X=0, OFF_Y=1, OFF_COMMIT=2, OFF_STATUS=3.
  - Bit positions: DEAD_BIT=10, WIN_BIT=11, START_BIT=12.
  - Masks: X_MASK=03FF, Y_MASK=1FFF.
  - Reset words: OUT1_RST=0000, OUT2_RST=1000.
  - FSM state encoding.
- The renderer and the CPU software header both consume these constants.
- Single module, no sub-module. Address decode, FSM, shadow/output registers and counter total roughly 150 lines.

## Test plan
- Reset: hold `rstN`=0, release → `out1`=0000, `out2`=1000, `pending`=0; STATUS read returns 0000.
- Write X=0x0456 (masked to 0x0056), Y=0x0C8, then COMMIT, then pulse `frame_tick` 5 cycles later → `out1`=0056 and `out2`=00C8, both exactly 1 cycle after the tick; `pending` is 1 before the tick and 0 after.
- Before COMMIT: write X=0x0010 and pulse `frame_tick` → `out1` unchanged; `frame_cnt` read = 1.
- While PENDING:
  - Write X=0x0099 → shadow keeps its old value.
  - STATUS read returns bit14=1, bit15=1; a second read returns bit14=0.
- COMMIT and `frame_tick` in the same cycle → no output change; the next tick transfers.
- 16384 ticks → `frame_cnt` wraps to 0; assert `rstN` low during PENDING → outputs reset asynchronously, `pending`=0.
